// File: rtl/pixel_mixer.sv
// pixel_mixer: registered RGB output stage for the video path.
//
// Composites up to LAYERS sprite/wall layers over a background by fixed
// priority (layer 0 wins), blanks outside the visible area, substitutes a
// flash colour on layer 0 during alternate frames of a "hit flash", and
// delays hsync/vsync through the same PIPE-stage pipeline as the colour so
// that rgb and sync stay aligned at the pins.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low reset
//   p_tick       pixel enable; pipeline and frame detection advance only here
//   video_on     visible-area flag
//   hsync_in     raw horizontal sync
//   vsync_in     raw vertical sync
//   layer_rgb    packed layer colours, layer i at [i*RGB_W +: RGB_W]
//   layer_on     per-layer pixel-hit flags
//   bg_rgb       background colour
//   flash_req    start/restart a flash (any clk edge)
//   flash_rgb    colour shown on layer 0 during flash-on frames
//   hsync/vsync  delayed syncs
//   rgb          composited, delayed pixel
//   flash_active high while a flash is in progress
//
// Flash FSM states:
//   state    | meaning
//   ST_IDLE  | no flash; layer 0 shown normally
//   ST_FLASH | flash running; phase 0 frames show flash_rgb on layer 0

module pixel_mixer #(
  parameter int unsigned RGB_W        = 3,
  parameter int unsigned LAYERS       = 4,
  parameter int unsigned PIPE         = 1,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter bit          SYNC_IDLE    = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       p_tick,
  input  logic                       video_on,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic [LAYERS*RGB_W-1:0]    layer_rgb,
  input  logic [LAYERS-1:0]          layer_on,
  input  logic [RGB_W-1:0]           bg_rgb,
  input  logic                       flash_req,
  input  logic [RGB_W-1:0]           flash_rgb,
  output logic                       hsync,
  output logic                       vsync,
  output logic [RGB_W-1:0]           rgb,
  output logic                       flash_active
);

  localparam logic [7:0] LAST_FRAME = 8'(FLASH_FRAMES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLASH = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic       vs_prev_q;
  logic       frame_edge;

  logic [RGB_W-1:0] pix_sel;
  logic [RGB_W-1:0] pix;

  logic [RGB_W-1:0] rgb_pipe [PIPE];
  logic [PIPE-1:0]  hs_pipe;
  logic [PIPE-1:0]  vs_pipe;

  // Frame boundary = vsync moving from idle to asserted on a pixel tick.
  assign frame_edge = p_tick && (vs_prev_q == SYNC_IDLE) && (vsync_in != SYNC_IDLE);

  assign flash_active = (state_q == ST_FLASH);

  // Fixed priority scan: walking from the top index down lets the lowest
  // asserted index overwrite everything above it.
  always_comb begin
    pix_sel = bg_rgb;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (layer_on[i]) begin
        pix_sel = layer_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

  always_comb begin
    pix = '0;
    if (video_on) begin
      if (flash_active && layer_on[0] && !phase_q) begin
        pix = flash_rgb;
      end else begin
        pix = pix_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      vs_prev_q <= SYNC_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      if (p_tick) begin
        vs_prev_q <= vsync_in;
      end
    end
  end

  // A request always restarts the flash, even on a boundary cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (flash_req) begin
          state_d = ST_FLASH;
          cnt_d   = '0;
          phase_d = 1'b0;
        end
      end
      ST_FLASH: begin
        if (flash_req) begin
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (frame_edge) begin
          if (cnt_q == LAST_FRAME) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            phase_d = ~phase_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < PIPE; i++) begin
        rgb_pipe[i] <= '0;
      end
      hs_pipe <= {PIPE{SYNC_IDLE}};
      vs_pipe <= {PIPE{SYNC_IDLE}};
    end else if (p_tick) begin
      rgb_pipe[0] <= pix;
      hs_pipe[0]  <= hsync_in;
      vs_pipe[0]  <= vsync_in;
      for (int i = 1; i < PIPE; i++) begin
        rgb_pipe[i] <= rgb_pipe[i-1];
        hs_pipe[i]  <= hs_pipe[i-1];
        vs_pipe[i]  <= vs_pipe[i-1];
      end
    end
  end

  assign rgb   = rgb_pipe[PIPE-1];
  assign hsync = hs_pipe[PIPE-1];
  assign vsync = vs_pipe[PIPE-1];

endmodule

// File: tb/tb_pixel_mixer.sv
// Testbench for pixel_mixer: two instances (4 layers x 3 bits, PIPE=2, and
// 1 layer x 8 bits, PIPE=3), both with a 4-frame flash. Expected pixels are
// pushed into per-instance queues by the driver; a monitor pops and compares.

module tb_pixel_mixer;

  localparam int FF     = 4;
  localparam int PIPE_A = 2;
  localparam int PIPE_B = 3;
  localparam int NCYC   = 7000;
  localparam int H_TOT  = 10;
  localparam int V_TOT  = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic        flash_req;

  logic [11:0] layer_rgb;
  logic [3:0]  layer_on;
  logic [2:0]  bg_rgb;
  logic [2:0]  flash_rgb;
  logic        hsync_a, vsync_a, fa_a;
  logic [2:0]  rgb_a;

  logic [7:0]  b_layer;
  logic [0:0]  b_on;
  logic [7:0]  b_bg;
  logic [7:0]  b_flash;
  logic        hsync_b, vsync_b, fa_b;
  logic [7:0]  rgb_b;

  always #5 clk = ~clk;

  pixel_mixer #(.RGB_W(3), .LAYERS(4), .PIPE(PIPE_A), .FLASH_FRAMES(FF), .SYNC_IDLE(1'b1)) dut_a (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_rgb(layer_rgb), .layer_on(layer_on),
    .bg_rgb(bg_rgb), .flash_req(flash_req), .flash_rgb(flash_rgb),
    .hsync(hsync_a), .vsync(vsync_a), .rgb(rgb_a), .flash_active(fa_a)
  );

  pixel_mixer #(.RGB_W(8), .LAYERS(1), .PIPE(PIPE_B), .FLASH_FRAMES(FF), .SYNC_IDLE(1'b1)) dut_b (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .layer_rgb(b_layer), .layer_on(b_on),
    .bg_rgb(b_bg), .flash_req(flash_req), .flash_rgb(b_flash),
    .hsync(hsync_b), .vsync(vsync_b), .rgb(rgb_b), .flash_active(fa_b)
  );

  // {rgb, hsync, vsync}
  localparam logic [4:0] RST_A = 5'b000_1_1;
  localparam logic [9:0] RST_B = 10'h003;

  logic [4:0] q_a[$];
  logic [9:0] q_b[$];
  logic [4:0] last_a;
  logic [9:0] last_b;

  int total = 0;
  int bad   = 0;

  // reference flash model: on/off plus number of frames elapsed since start
  bit m_flash_on  = 1'b0;
  int m_frames    = 0;
  bit m_prev_vs   = 1'b1;
  int hcnt = 0;
  int vcnt = 0;
  int stall = 0;
  int coincident = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_pix_a(bit sub);
    logic [2:0] r;
    int sel;
    sel = -1;
    for (int i = 0; i < 4; i++)
      if (sel < 0 && layer_on[i]) sel = i;
    if (!video_on) r = 3'd0;
    else if (sel < 0) r = bg_rgb;
    else if (sel == 0 && sub) r = flash_rgb;
    else r = layer_rgb[sel*3 +: 3];
    return r;
  endfunction

  function automatic logic [7:0] ref_pix_b(bit sub);
    if (!video_on) return 8'd0;
    if (!b_on[0]) return b_bg;
    if (sub) return b_flash;
    return b_layer;
  endfunction

  // monitor
  initial begin
    last_a = RST_A;
    last_b = RST_B;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        chk("rst_a", {rgb_a, hsync_a, vsync_a}, RST_A);
        chk("rst_b", {rgb_b, hsync_b, vsync_b}, RST_B);
        last_a = RST_A;
        last_b = RST_B;
      end else if (p_tick) begin
        if (q_a.size() == 0) begin
          total++; bad++;
          $display("FAIL queue_a: empty at %0t", $time);
        end else begin
          last_a = q_a.pop_front();
          chk("pix_a", {rgb_a, hsync_a, vsync_a}, last_a);
        end
        if (q_b.size() == 0) begin
          total++; bad++;
          $display("FAIL queue_b: empty at %0t", $time);
        end else begin
          last_b = q_b.pop_front();
          chk("pix_b", {rgb_b, hsync_b, vsync_b}, last_b);
        end
      end else begin
        chk("hold_a", {rgb_a, hsync_a, vsync_a}, last_a);
        chk("hold_b", {rgb_b, hsync_b, vsync_b}, last_b);
      end
      chk("flash_a", fa_a, m_flash_on);
      chk("flash_b", fa_b, m_flash_on);
    end
  end

  // driver + reference model
  initial begin
    bit boundary, sub, at_edge;
    reset = 1'b0; p_tick = 1'b0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    flash_req = 1'b0; layer_rgb = '0; layer_on = '0; bg_rgb = '0; flash_rgb = '0;
    b_layer = '0; b_on = '0; b_bg = '0; b_flash = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      layer_rgb = 12'($urandom);
      layer_on  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      bg_rgb    = 3'($urandom);
      flash_rgb = 3'($urandom);
      b_layer   = 8'($urandom);
      b_on      = 1'($urandom);
      b_bg      = 8'($urandom);
      b_flash   = 8'($urandom);

      reset = !(cyc < 3 || (cyc >= 2500 && cyc < 2502) || (cyc >= 4700 && cyc < 4703));

      if (cyc < 3) begin
        p_tick = cyc[0];
        layer_on = 4'hF;
        b_on = 1'b1;
      end else if (stall > 0) begin
        p_tick = 1'b0;
        stall--;
      end else if ($urandom_range(0, 199) == 0) begin
        p_tick = 1'b0;
        stall = 9;
      end else begin
        p_tick = ($urandom_range(0, 99) < 70);
      end

      if (p_tick) begin
        hsync_in = !(hcnt >= 8);
        vsync_in = !(vcnt == 5);
        video_on = (hcnt < 7) && (vcnt < 4);
      end else begin
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
        video_on = 1'($urandom);
      end

      at_edge = p_tick && hcnt == 0 && vcnt == 5;
      flash_req = ($urandom_range(0, 399) == 0) || cyc == 20 || cyc == 2450 || cyc == 4650;
      if (at_edge && m_flash_on && m_frames >= 1 && $urandom_range(0, 1) == 1) flash_req = 1'b1;

      if (!reset) begin
        q_a.delete();
        q_b.delete();
        for (int i = 0; i < PIPE_A - 1; i++) q_a.push_back(RST_A);
        for (int i = 0; i < PIPE_B - 1; i++) q_b.push_back(RST_B);
        m_flash_on = 1'b0;
        m_frames   = 0;
        m_prev_vs  = 1'b1;
      end else begin
        boundary = p_tick && m_prev_vs && !vsync_in;
        sub = m_flash_on && (m_frames % 2 == 0);
        if (p_tick) begin
          q_a.push_back({ref_pix_a(sub), hsync_in, vsync_in});
          q_b.push_back({ref_pix_b(sub), hsync_in, vsync_in});
        end
        if (flash_req) begin
          if (boundary && m_flash_on) coincident++;
          m_flash_on = 1'b1;
          m_frames   = 0;
        end else if (boundary && m_flash_on) begin
          m_frames++;
          if (m_frames == FF) begin
            m_flash_on = 1'b0;
            m_frames   = 0;
          end
        end
        if (p_tick) m_prev_vs = vsync_in;
      end

      if (p_tick) begin
        hcnt++;
        if (hcnt == H_TOT) begin
          hcnt = 0;
          vcnt = (vcnt + 1) % V_TOT;
        end
      end
    end
    @(negedge clk);
    reset = 1'b1; p_tick = 1'b0; flash_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
